// File: rtl/branch_resolver_serial_pkg.sv
// Shared definitions for the serial branch resolver: slice width, funct3
// encodings, FSM state encoding and the branch-decision helper.
package branch_resolver_serial_pkg;

    localparam int SLICE_W = 4;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // funct3 010/011 do not encode a conditional branch.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // Branch decision from comparison flags; illegal encodings never take.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zf,
                                          input logic slt, input logic sltu);
        logic t;
        case (f3)
            F3_BEQ:  t = zf;
            F3_BNE:  t = !zf;
            F3_BLT:  t = slt;
            F3_BGE:  t = !slt;
            F3_BLTU: t = sltu;
            F3_BGEU: t = !sltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_resolver_serial_nibble_cmp.sv
// 4-bit slice comparator.
//   a, b  : slice operands
//   eq    : a == b
//   lt_u  : a < b, unsigned
//   lt_s  : a < b, two's-complement (used only for the top slice)
module nibble_cmp
    import branch_resolver_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               eq,
    output logic               lt_u,
    output logic               lt_s
);

    assign eq   = (a == b);
    assign lt_u = (a < b);
    assign lt_s = ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolver_serial.sv
// Iterative RISC-V branch resolver. Compares rs1/rs2 one 4-bit slice per
// cycle, most significant slice first, then produces the branch decision
// and next PC.
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake (ready only in IDLE)
//   in_rs1, in_rs2        operands
//   in_funct3, in_pc,     branch encoding, instruction PC, sign-extended
//   in_imm                offset
//   out_valid/out_ready   result handshake (result held until accepted)
//   out_taken, out_target decision and next PC (pc+imm or pc+4, wrapping)
//   out_illegal           funct3 was 010/011
//   out_zf/slt/sltu       equality, signed-less, unsigned-less flags
module branch_resolver_serial
    import branch_resolver_serial_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic            out_zf,
    output logic            out_slt,
    output logic            out_sltu
);

    localparam int NSLICE = XLEN / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t state_q, state_n;

    logic [IDX_W-1:0] idx_q;
    logic             hit_q;
    logic             zf_q, slt_q, sltu_q;
    logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, imm_q;
    logic [2:0]       f3_q;

    logic [SLICE_W-1:0] sl_a, sl_b;
    logic               sl_eq, sl_ltu, sl_lts;
    logic               is_top, is_last, new_hit, scan_done;
    logic               zf_n, slt_n, sltu_n, taken_n, illegal_n;

    // Single comparator shared across all slices, steered by idx.
    assign sl_a = rs1_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign sl_b = rs2_q[int'(idx_q)*SLICE_W +: SLICE_W];

    nibble_cmp u_cmp (
        .a    (sl_a),
        .b    (sl_b),
        .eq   (sl_eq),
        .lt_u (sl_ltu),
        .lt_s (sl_lts)
    );

    assign is_top    = (idx_q == IDX_W'(NSLICE - 1));
    assign is_last   = (idx_q == '0);
    assign new_hit   = !hit_q && !sl_eq;
    assign scan_done = is_last || ((EARLY_EXIT != 0) && new_hit);

    // Flag values as they stand at the end of this SCAN cycle. Only the top
    // slice carries the sign, so lower slices compare unsigned for slt too.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        zf_n   = zf_q;
        slt_n  = slt_q;
        sltu_n = sltu_q;
        if (new_hit) begin
            zf_n   = 1'b0;
            sltu_n = sl_ltu;
            slt_n  = is_top ? sl_lts : sl_ltu;
        end else if (!hit_q && is_last) begin
            zf_n   = 1'b1;
            slt_n  = 1'b0;
            sltu_n = 1'b0;
        end
    end

    assign illegal_n = f3_illegal(f3_q);
    assign taken_n   = !illegal_n && branch_taken(f3_q, zf_n, slt_n, sltu_n);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_n;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_n = ST_SCAN;
            ST_SCAN: if (scan_done) state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        // NOTE: the latched operands are reset along with control state so
        // outputs read all-zero after reset; the block is small enough that
        // this costs nothing worth avoiding.
        if (!rst_n) begin
            idx_q       <= '0;
            hit_q       <= 1'b0;
            zf_q        <= 1'b0;
            slt_q       <= 1'b0;
            sltu_q      <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            f3_q        <= '0;
            out_taken   <= 1'b0;
            out_target  <= '0;
            out_illegal <= 1'b0;
            out_zf      <= 1'b0;
            out_slt     <= 1'b0;
            out_sltu    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        rs1_q  <= in_rs1;
                        rs2_q  <= in_rs2;
                        pc_q   <= in_pc;
                        imm_q  <= in_imm;
                        f3_q   <= in_funct3;
                        idx_q  <= IDX_W'(NSLICE - 1);
                        hit_q  <= 1'b0;
                        zf_q   <= 1'b0;
                        slt_q  <= 1'b0;
                        sltu_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    zf_q   <= zf_n;
                    slt_q  <= slt_n;
                    sltu_q <= sltu_n;
                    if (new_hit) hit_q <= 1'b1;
                    if (scan_done) begin
                        out_zf      <= zf_n;
                        out_slt     <= slt_n;
                        out_sltu    <= sltu_n;
                        out_illegal <= illegal_n;
                        out_taken   <= taken_n;
                        out_target  <= taken_n ? (pc_q + imm_q) : (pc_q + XLEN'(4));
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver_serial.sv
// Scoreboard bench: two resolvers (early exit on / off) share stimulus; the
// driver pushes hand-computed results at accept time, monitors pop on each
// output handshake and compare fields and latency.
module tb_branch_resolver_serial;
    import branch_resolver_serial_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
    logic [2:0]  in_funct3;
    logic        out_ready;

    logic        rdy1, val1, tk1, ill1, zf1, slt1, sltu1;
    logic [31:0] tgt1;
    logic        rdy2, val2, tk2, ill2, zf2, slt2, sltu2;
    logic [31:0] tgt2;

    always #5 clk = ~clk;

    branch_resolver_serial #(.XLEN(32), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_pc(in_pc),
        .in_imm(in_imm), .out_valid(val1), .out_ready(out_ready), .out_taken(tk1),
        .out_target(tgt1), .out_illegal(ill1), .out_zf(zf1), .out_slt(slt1),
        .out_sltu(sltu1)
    );

    branch_resolver_serial #(.XLEN(32), .EARLY_EXIT(0)) dut_const (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_pc(in_pc),
        .in_imm(in_imm), .out_valid(val2), .out_ready(out_ready), .out_taken(tk2),
        .out_target(tgt2), .out_illegal(ill2), .out_zf(zf2), .out_slt(slt2),
        .out_sltu(sltu2)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        illegal;
        logic        zf;
        logic        slt;
        logic        sltu;
        int          lat;   // cycle label of out_valid relative to accept edge T
        int          acc;   // cycle count at accept edge
    } exp_t;

    exp_t q1[$], q2[$];
    exp_t e1, e2;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   first1, first2;
    bit   seen1 = 1'b0, seen2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic taken, input logic [31:0] target,
                                input logic illegal, input logic zf, input logic slt,
                                input logic sltu, input int lat);
        exp_t e;
        e.taken = taken; e.target = target; e.illegal = illegal;
        e.zf = zf; e.slt = slt; e.sltu = sltu; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Output first seen after edge T+k is cycle label T+k+1.
    always @(negedge clk) begin
        if (rst_n && val1) begin
            if (!seen1) begin seen1 = 1'b1; first1 = cyc; end
            if (out_ready) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL early_unexpected_output: got target %0h expected none", tgt1);
                end else begin
                    e1 = q1.pop_front();
                    check("early_taken",   64'(tk1),   64'(e1.taken));
                    check("early_target",  64'(tgt1),  64'(e1.target));
                    check("early_illegal", 64'(ill1),  64'(e1.illegal));
                    check("early_zf",      64'(zf1),   64'(e1.zf));
                    check("early_slt",     64'(slt1),  64'(e1.slt));
                    check("early_sltu",    64'(sltu1), 64'(e1.sltu));
                    check("early_latency", 64'(first1 - e1.acc + 1), 64'(e1.lat));
                end
                seen1 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && val2) begin
            if (!seen2) begin seen2 = 1'b1; first2 = cyc; end
            if (out_ready) begin
                if (q2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL const_unexpected_output: got target %0h expected none", tgt2);
                end else begin
                    e2 = q2.pop_front();
                    check("const_taken",   64'(tk2),   64'(e2.taken));
                    check("const_target",  64'(tgt2),  64'(e2.target));
                    check("const_illegal", 64'(ill2),  64'(e2.illegal));
                    check("const_zf",      64'(zf2),   64'(e2.zf));
                    check("const_slt",     64'(slt2),  64'(e2.slt));
                    check("const_sltu",    64'(sltu2), 64'(e2.sltu));
                    check("const_latency", 64'(first2 - e2.acc + 1), 64'(e2.lat));
                end
                seen2 = 1'b0;
            end
        end
    end

    // Present a request until accepted; expected results enter the
    // scoreboards at the accept edge.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input exp_t x1, input exp_t x2, input bit expect_out);
        bit r, acc;
        @(posedge clk); #1;
        in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk); r = rdy1;
            @(posedge clk);
            if (r) acc = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no in_ready expected accept");
        end else if (expect_out) begin
            x1.acc = cyc; x2.acc = cyc;
            q1.push_back(x1);
            q2.push_back(x2);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q1.size(), q2.size());
            q1.delete(); q2.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_out;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0; in_funct3 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready",  64'(rdy1), 64'd1);
        check("reset_out_valid", 64'(val1), 64'd0);
        check("reset_taken",     64'(tk1),  64'd0);
        check("reset_target",    64'(tgt1), 64'd0);
        check("reset_flags",     64'({ill1, zf1, slt1, sltu1}), 64'd0);

        // 1: BEQ equal operands, full scan.
        send(F3_BEQ, 32'h12345678, 32'h12345678, 32'h100, 32'h20,
             mk(1, 32'h120, 0, 1, 0, 0, 9), mk(1, 32'h120, 0, 1, 0, 0, 9), 1);
        drain();
        // 2: BLT -1 vs 1, top-slice hit.
        send(F3_BLT, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40,
             mk(1, 32'h240, 0, 0, 1, 0, 2), mk(1, 32'h240, 0, 0, 1, 0, 9), 1);
        drain();
        send(F3_BLTU, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40,
             mk(0, 32'h204, 0, 0, 1, 0, 2), mk(0, 32'h204, 0, 0, 1, 0, 9), 1);
        drain();
        // 3: BGE 5 vs 3, difference only in slice 0, negative offset.
        send(F3_BGE, 32'h5, 32'h3, 32'h300, 32'hFFFFFFF0,
             mk(1, 32'h2F0, 0, 0, 0, 0, 9), mk(1, 32'h2F0, 0, 0, 0, 0, 9), 1);
        drain();
        // BLTU 0 vs 0x80000000: unsigned less, signed not less.
        send(F3_BLTU, 32'h0, 32'h80000000, 32'h500, 32'h10,
             mk(1, 32'h510, 0, 0, 0, 1, 2), mk(1, 32'h510, 0, 0, 0, 1, 9), 1);
        drain();
        // BGEU equal, pc+imm wraps.
        send(F3_BGEU, 32'h3, 32'h3, 32'hFFFFFFF0, 32'h20,
             mk(1, 32'h10, 0, 1, 0, 0, 9), mk(1, 32'h10, 0, 1, 0, 0, 9), 1);
        drain();
        // BEQ not taken, pc+4 wraps; slice-0 hit uses unsigned for slt.
        send(F3_BEQ, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h40,
             mk(0, 32'h0, 0, 0, 1, 1, 9), mk(0, 32'h0, 0, 0, 1, 1, 9), 1);
        drain();
        // 6: illegal funct3.
        send(3'b010, 32'h1, 32'h2, 32'h40, 32'h100,
             mk(0, 32'h44, 1, 0, 1, 1, 9), mk(0, 32'h44, 1, 0, 1, 1, 9), 1);
        drain();

        // 4: backpressure. BNE 0xA0000000 vs 0x50000000: top slice A(-6) vs 5.
        #0 out_ready = 1'b0;
        send(F3_BNE, 32'hA0000000, 32'h50000000, 32'h400, 32'h8,
             mk(1, 32'h408, 0, 0, 1, 0, 2), mk(1, 32'h408, 0, 0, 1, 0, 9), 1);
        for (int i = 0; i < 20 && !val1; i++) @(negedge clk);
        check("stall_out_valid", 64'(val1), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            in_rs1 = 32'h0BAD0000 + 32'(i); in_rs2 = 32'h1; in_funct3 = F3_BEQ;
            in_pc = 32'h9000; in_imm = 32'h4;
            @(negedge clk);
            check("stall_valid",    64'(val1), 64'd1);
            check("stall_target",   64'(tgt1), 64'h408);
            check("stall_taken",    64'(tk1),  64'd1);
            check("stall_in_ready", 64'(rdy1), 64'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready",  64'(rdy1), 64'd1);
        check("release_out_valid", 64'(val1), 64'd0);
        drain();

        // 5: reset mid-SCAN discards the request.
        send(F3_BEQ, 32'h77777777, 32'h77777777, 32'h600, 32'h8,
             mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready",        64'(rdy1), 64'd1);
        check("abort_out_valid",       64'(val1), 64'd0);
        check("abort_const_in_ready",  64'(rdy2), 64'd1);
        check("abort_const_out_valid", 64'(val2), 64'd0);
        seen_out = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (val1 || val2) seen_out = 1'b1;
        end
        check("abort_no_output", 64'(seen_out), 64'd0);

        // Normal operation after abort.
        send(F3_BNE, 32'h10, 32'h10, 32'h700, 32'h100,
             mk(0, 32'h704, 0, 1, 0, 0, 9), mk(0, 32'h704, 0, 1, 0, 0, 9), 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
